yd_q_h_block_sequencer: RTL and testbench

- Front-end controller for the luminance DCT/quantize/Huffman pipeline.
- Accepts Y pixels over a valid/ready handshake and buffers one full 8x8 block (64 pixels).
- Launches each block into the pipeline as exactly 64 contiguous enable-high beats, then enforces a minimum idle gap.
- Limits the number of in-flight blocks using the pipeline's end-of-block pulses.

---
 rtl/yd_q_h_block_sequencer.sv | 290 +++++++++++++++++++++++++++++
 tb/tb_yd_q_h_block_sequencer.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/yd_q_h_block_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : yd_q_h_block_sequencer
// Purpose  : Front-end controller for the luminance DCT/quantize/Huffman
//            pipeline. Buffers one 8x8 block of Y pixels, launches it as 64
//            contiguous enable beats, enforces a minimum idle gap and limits
//            the number of in-flight blocks using end-of-block pulses.
// Options  : YD_Q_H_SEQ_PINGPONG_EN - two 64-entry banks with independent
//            fill and stream sub-FSMs (default build: single bank).
// Revision : 1.0 - initial release
// ============================================================================
module yd_q_h_block_sequencer #(
  parameter int MIN_GAP         = 4,
  parameter int MAX_OUTSTANDING = 2,
  parameter int CNT_W           = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             s_valid,
  output logic             s_ready,
  input  logic [7:0]       s_data,
  output logic             dq_enable,
  output logic [7:0]       dq_data,
  input  logic             dq_eob,
  output logic [3:0]       outstanding,
  output logic [CNT_W-1:0] blk_launched,
  output logic [CNT_W-1:0] blk_retired,
  output logic             eob_err,
  output logic             busy
);

  typedef enum logic [1:0] {
    ST_FILL   = 2'd0,
    ST_WAIT   = 2'd1,
    ST_STREAM = 2'd2,
    ST_GAP    = 2'd3
  } state_t;

  localparam logic [3:0] C_MAX_OUT  = 4'(MAX_OUTSTANDING);
  localparam logic [7:0] C_GAP_LOAD = 8'(MIN_GAP - 1);
`ifdef YD_Q_H_SEQ_PINGPONG_EN
  localparam int C_AW = 7;
`else
  localparam int C_AW = 6;
`endif
  localparam int C_DEPTH = 1 << C_AW;

  logic [7:0] mem [0:C_DEPTH-1];

  state_t           state_q, state_d;
  logic [5:0]       wr_idx_q, wr_idx_d;
  logic [5:0]       rd_idx_q, rd_idx_d;
  logic [7:0]       gap_cnt_q, gap_cnt_d;
  logic             s_ready_q, s_ready_d;
  logic             dq_enable_q, dq_enable_d;
  logic [7:0]       dq_data_q, dq_data_d;
  logic [3:0]       outstanding_q, outstanding_d;
  logic [CNT_W-1:0] blk_launched_q, blk_launched_d;
  logic [CNT_W-1:0] blk_retired_q, blk_retired_d;
  logic             eob_err_q, eob_err_d;
  logic             busy_q, busy_d;

  logic             w_accept;
  logic             w_launch;
  logic             w_wr_en;
  logic             w_slot_free;
  logic             w_eob_ok;
  logic [C_AW-1:0]  w_wr_addr;
  logic [C_AW-1:0]  w_rd_addr;

  assign w_accept    = s_valid && s_ready_q;
  assign w_slot_free = (outstanding_q < C_MAX_OUT);
  assign w_eob_ok    = dq_eob && (outstanding_q != 4'd0);

`ifdef YD_Q_H_SEQ_PINGPONG_EN
  logic       wr_bank_q, wr_bank_d;
  logic       rd_bank_q, rd_bank_d;
  logic [1:0] full_q, full_d;
  logic [1:0] w_full_set;
  logic [1:0] w_full_clr;

  // Fill and stream sub-FSMs working on opposite banks; state tracks streaming.
  always_comb begin
    state_d     = state_q;
    wr_idx_d    = wr_idx_q;
    rd_idx_d    = rd_idx_q;
    gap_cnt_d   = gap_cnt_q;
    wr_bank_d   = wr_bank_q;
    rd_bank_d   = rd_bank_q;
    dq_enable_d = 1'b0;
    dq_data_d   = 8'd0;
    w_launch    = 1'b0;
    w_wr_en     = 1'b0;
    w_full_set  = 2'b00;
    w_full_clr  = 2'b00;
    w_wr_addr   = {wr_bank_q, wr_idx_q};
    w_rd_addr   = {rd_bank_q, rd_idx_q};

    if (w_accept) begin
      w_wr_en  = 1'b1;
      wr_idx_d = wr_idx_q + 6'd1;
      if (wr_idx_q == 6'd63) begin
        w_full_set[wr_bank_q] = 1'b1;
        wr_bank_d             = ~wr_bank_q;
      end
    end

    case (state_q)
      ST_FILL, ST_WAIT: begin
        if (full_q[rd_bank_q]) begin
          if (w_slot_free && (gap_cnt_q == 8'd0)) begin
            w_launch    = 1'b1;
            state_d     = ST_STREAM;
            dq_enable_d = 1'b1;
            dq_data_d   = mem[w_rd_addr];
            rd_idx_d    = rd_idx_q + 6'd1;
          end else begin
            state_d = ST_WAIT;
          end
        end else begin
          state_d = ST_FILL;
        end
      end
      ST_STREAM: begin
        dq_enable_d = 1'b1;
        dq_data_d   = mem[w_rd_addr];
        rd_idx_d    = rd_idx_q + 6'd1;
        if (rd_idx_q == 6'd63) begin
          w_full_clr[rd_bank_q] = 1'b1;
          rd_bank_d             = ~rd_bank_q;
          state_d               = ST_GAP;
          gap_cnt_d             = C_GAP_LOAD;
        end
      end
      ST_GAP: begin
        if (gap_cnt_q == 8'd0) begin
          state_d = ST_FILL;
        end else begin
          gap_cnt_d = gap_cnt_q - 8'd1;
        end
      end
      default: state_d = ST_FILL;
    endcase

    full_d    = (full_q | w_full_set) & ~w_full_clr;
    s_ready_d = ~full_d[wr_bank_d];
    busy_d    = (state_d != ST_FILL) || (wr_idx_d != 6'd0);
  end

  // Bank pointers and full flags.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_bank_q <= 1'b0;
      rd_bank_q <= 1'b0;
      full_q    <= 2'b00;
    end else begin
      wr_bank_q <= wr_bank_d;
      rd_bank_q <= rd_bank_d;
      full_q    <= full_d;
    end
  end
`else
  // Single-bank sequencer: fill, wait for a slot, stream 64 beats, idle gap.
  always_comb begin
    state_d     = state_q;
    wr_idx_d    = wr_idx_q;
    rd_idx_d    = rd_idx_q;
    gap_cnt_d   = gap_cnt_q;
    dq_enable_d = 1'b0;
    dq_data_d   = 8'd0;
    w_launch    = 1'b0;
    w_wr_en     = 1'b0;
    w_wr_addr   = wr_idx_q;
    w_rd_addr   = rd_idx_q;

    case (state_q)
      ST_FILL: begin
        if (w_accept) begin
          w_wr_en  = 1'b1;
          wr_idx_d = wr_idx_q + 6'd1;
          if (wr_idx_q == 6'd63) begin
            state_d = ST_WAIT;
          end
        end
      end
      ST_WAIT: begin
        // The decision edge already drives beat 0 so the block is contiguous.
        if (w_slot_free && (gap_cnt_q == 8'd0)) begin
          w_launch    = 1'b1;
          state_d     = ST_STREAM;
          dq_enable_d = 1'b1;
          dq_data_d   = mem[w_rd_addr];
          rd_idx_d    = rd_idx_q + 6'd1;
        end
      end
      ST_STREAM: begin
        dq_enable_d = 1'b1;
        dq_data_d   = mem[w_rd_addr];
        rd_idx_d    = rd_idx_q + 6'd1;
        if (rd_idx_q == 6'd63) begin
          state_d   = ST_GAP;
          gap_cnt_d = C_GAP_LOAD;
        end
      end
      ST_GAP: begin
        if (gap_cnt_q == 8'd0) begin
          state_d = ST_FILL;
        end else begin
          gap_cnt_d = gap_cnt_q - 8'd1;
        end
      end
      default: state_d = ST_FILL;
    endcase

    s_ready_d = (state_d == ST_FILL);
    busy_d    = (state_d != ST_FILL) || (wr_idx_d != 6'd0);
  end
`endif

  // In-flight accounting and statistics; a stray dq_eob is flagged, not counted.
  always_comb begin
    outstanding_d  = outstanding_q;
    blk_launched_d = blk_launched_q;
    blk_retired_d  = blk_retired_q;
    eob_err_d      = eob_err_q;
    case ({w_launch, w_eob_ok})
      2'b10:   outstanding_d = outstanding_q + 4'd1;
      2'b01:   outstanding_d = outstanding_q - 4'd1;
      default: outstanding_d = outstanding_q;
    endcase
    if (w_launch) begin
      blk_launched_d = blk_launched_q + CNT_W'(1);
    end
    if (w_eob_ok) begin
      blk_retired_d = blk_retired_q + CNT_W'(1);
    end
    if (dq_eob && (outstanding_q == 4'd0)) begin
      eob_err_d = 1'b1;
    end
  end

  // Control and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= ST_FILL;
      wr_idx_q       <= 6'd0;
      rd_idx_q       <= 6'd0;
      gap_cnt_q      <= 8'd0;
      s_ready_q      <= 1'b0;
      dq_enable_q    <= 1'b0;
      dq_data_q      <= 8'd0;
      outstanding_q  <= 4'd0;
      blk_launched_q <= '0;
      blk_retired_q  <= '0;
      eob_err_q      <= 1'b0;
      busy_q         <= 1'b0;
    end else begin
      state_q        <= state_d;
      wr_idx_q       <= wr_idx_d;
      rd_idx_q       <= rd_idx_d;
      gap_cnt_q      <= gap_cnt_d;
      s_ready_q      <= s_ready_d;
      dq_enable_q    <= dq_enable_d;
      dq_data_q      <= dq_data_d;
      outstanding_q  <= outstanding_d;
      blk_launched_q <= blk_launched_d;
      blk_retired_q  <= blk_retired_d;
      eob_err_q      <= eob_err_d;
      busy_q         <= busy_d;
    end
  end

  // Pixel storage; contents need no reset since indices restart at 0.
  always_ff @(posedge clk) begin
    if (w_wr_en) begin
      mem[w_wr_addr] <= s_data;
    end
  end

  assign s_ready      = s_ready_q;
  assign dq_enable    = dq_enable_q;
  assign dq_data      = dq_data_q;
  assign outstanding  = outstanding_q;
  assign blk_launched = blk_launched_q;
  assign blk_retired  = blk_retired_q;
  assign eob_err      = eob_err_q;
  assign busy         = busy_q;

endmodule
`default_nettype wire

// File: tb/tb_yd_q_h_block_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_yd_q_h_block_sequencer
// Purpose  : Self-checking bench for yd_q_h_block_sequencer (single-bank
//            build). A block-level timestamp model predicts handshake,
//            beat windows, pixel order and counter values every cycle.
// Revision : 1.0 - initial release
// ============================================================================
module tb_yd_q_h_block_sequencer;

  localparam int MIN_GAP = 4;
  localparam int MAX_OUT = 2;
  localparam int CNT_W   = 16;
  localparam longint INF = 64'h3fff_ffff_ffff_ffff;

  logic             clk = 1'b0;
  logic             rst_n = 1'b1;
  logic             s_valid = 1'b0;
  logic             s_ready;
  logic [7:0]       s_data = 8'd0;
  logic             dq_enable;
  logic [7:0]       dq_data;
  logic             dq_eob = 1'b0;
  logic [3:0]       outstanding;
  logic [CNT_W-1:0] blk_launched;
  logic [CNT_W-1:0] blk_retired;
  logic             eob_err;
  logic             busy;

  yd_q_h_block_sequencer #(
    .MIN_GAP        (MIN_GAP),
    .MAX_OUTSTANDING(MAX_OUT),
    .CNT_W          (CNT_W)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .s_valid     (s_valid),
    .s_ready     (s_ready),
    .s_data      (s_data),
    .dq_enable   (dq_enable),
    .dq_data     (dq_data),
    .dq_eob      (dq_eob),
    .outstanding (outstanding),
    .blk_launched(blk_launched),
    .blk_retired (blk_retired),
    .eob_err     (eob_err),
    .busy        (busy)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Single comparison point for the whole bench.
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // ---------------- reference model (block timestamps) ----------------
  longint     cyc = 0;
  longint     fill_from, ready_from, pend_ready, sb;
  bit         pend, strm, last_acc;
  int         fill_cnt, m_out, m_launch, m_retire;
  bit         m_err;
  logic [7:0] fill_buf [64];
  logic [7:0] pend_buf [64];
  logic [7:0] strm_buf [64];

  int beat_cnt = 0;
  always @(negedge clk) if (rst_n && dq_enable) beat_cnt++;

  function automatic bit exp_en();
    return strm && (cyc >= sb) && (cyc <= sb + 63);
  endfunction

  task automatic model_reset();
    fill_from  = cyc;
    ready_from = cyc + 1;
    pend = 0; strm = 0; fill_cnt = 0;
    m_out = 0; m_launch = 0; m_retire = 0; m_err = 0;
    pend_ready = INF; sb = -1000;
  endtask

  task automatic check_outputs();
    bit en;
    bit in_fill;
    en      = exp_en();
    in_fill = (cyc >= fill_from);
    chk("s_ready", s_ready, (cyc >= ready_from));
    chk("dq_enable", dq_enable, en);
    if (en) chk("dq_data", dq_data, strm_buf[int'(cyc - sb)]);
    chk("outstanding", outstanding, m_out);
    chk("blk_launched", blk_launched, m_launch & 32'hffff);
    chk("blk_retired", blk_retired, m_retire & 32'hffff);
    chk("eob_err", eob_err, m_err);
    chk("busy", busy, !(in_fill && fill_cnt == 0));
  endtask

  task automatic model_update(input bit v, input logic [7:0] d, input bit e);
    bit acc;
    bit launch;
    acc      = v && (cyc >= ready_from);
    last_acc = acc;
    launch   = pend && (cyc >= pend_ready) && (m_out < MAX_OUT);
    if (acc) begin
      fill_buf[fill_cnt] = d;
      fill_cnt++;
      if (fill_cnt == 64) begin
        pend       = 1;
        pend_buf   = fill_buf;
        pend_ready = cyc + 1;
        fill_from  = INF;
        ready_from = INF;
        fill_cnt   = 0;
      end
    end
    if (e) begin
      if (m_out == 0) m_err = 1;
      else begin m_out--; m_retire++; end
    end
    if (launch) begin
      strm       = 1;
      strm_buf   = pend_buf;
      pend       = 0;
      sb         = cyc + 1;
      fill_from  = cyc + 64 + MIN_GAP;
      ready_from = cyc + 64 + MIN_GAP;
      m_out++;
      m_launch++;
    end
  endtask

  // ---------------- stimulus helpers ----------------
  task automatic cyc_step(input bit v, input logic [7:0] d, input bit e);
    @(posedge clk);
    #1;
    cyc++;
    check_outputs();
    s_valid = v;
    s_data  = d;
    dq_eob  = e;
    model_update(v, d, e);
  endtask

  function automatic bit rand_eob(input int eprob);
    return (eprob > 0) && ($urandom_range(999) < eprob);
  endfunction

  task automatic idle(input int n, input int eprob);
    for (int i = 0; i < n; i++) cyc_step(1'b0, 8'h00, rand_eob(eprob));
  endtask

  task automatic feed(input int cnt, input bit seq, input int vprob, input int eprob);
    int n = 0;
    int budget = 3000;
    while (n < cnt && budget > 0) begin
      cyc_step(($urandom_range(99) < vprob), seq ? 8'(n) : 8'($urandom), rand_eob(eprob));
      if (last_acc) n++;
      budget--;
    end
    chk("feed_count", n, cnt);
  endtask

  task automatic do_reset();
    rst_n   = 1'b0;
    s_valid = 1'b0;
    dq_eob  = 1'b0;
    #1;
    chk("rst_s_ready", s_ready, 0);
    chk("rst_dq_enable", dq_enable, 0);
    chk("rst_dq_data", dq_data, 0);
    chk("rst_outstanding", outstanding, 0);
    chk("rst_launched", blk_launched, 0);
    chk("rst_retired", blk_retired, 0);
    chk("rst_eob_err", eob_err, 0);
    chk("rst_busy", busy, 0);
    repeat (3) begin @(posedge clk); cyc++; end
    #1;
    chk("rst_hold_s_ready", s_ready, 0);
    chk("rst_hold_dq_enable", dq_enable, 0);
    rst_n = 1'b1;
    model_reset();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    int budget;
    #2;
    // Reset then idle.
    do_reset();
    idle(10, 0);

    // Single sequential block, no retirement.
    beat_cnt = 0;
    feed(64, 1'b1, 100, 0);
    idle(80, 0);
    chk("single_beats", beat_cnt, 64);
    chk("single_outstanding", outstanding, 1);
    chk("single_launched", blk_launched, 1);

    // Fill the remaining slot, then a third block must wait in backpressure.
    feed(64, 1'b0, 70, 0);
    idle(80, 0);
    feed(64, 1'b0, 70, 0);
    idle(150, 0);
    chk("bp_s_ready", s_ready, 0);
    chk("bp_outstanding", outstanding, MAX_OUT);
    cyc_step(1'b0, 8'h00, 1'b1);
    idle(80, 0);

    // Drain to zero, then a stray eob sets the sticky error.
    idle(3, 0); cyc_step(1'b0, 8'h00, 1'b1);
    idle(3, 0); cyc_step(1'b0, 8'h00, 1'b1);
    idle(3, 0); cyc_step(1'b0, 8'h00, 1'b1);
    idle(5, 0);
    chk("err_set", eob_err, 1);
    chk("err_retired", blk_retired, 3);
    chk("err_outstanding", outstanding, 0);

    // Randomized traffic with random retirement.
    for (int b = 0; b < 12; b++) begin
      feed(64, 1'b0, 60, 15);
      idle($urandom_range(0, 40), 15);
    end
    idle(100, 20);

    // Reset in the middle of a fill; next block must be clean.
    do_reset();
    feed(30, 1'b0, 80, 0);
    do_reset();
    feed(64, 1'b1, 100, 0);
    idle(80, 0);

    // Reset in the middle of a stream at beat 20.
    do_reset();
    feed(64, 1'b1, 90, 0);
    budget = 200;
    while (!(strm && cyc == sb + 20) && budget > 0) begin
      cyc_step(1'b0, 8'h00, 1'b0);
      budget--;
    end
    chk("mid_stream_reached", budget > 0, 1);
    do_reset();
    feed(64, 1'b1, 100, 0);
    idle(80, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
